// File: rtl/mul_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and payload stable until that edge, and the receiver
// may raise or drop ready freely.
interface mul_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_word;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_word, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_word, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative RISC-V M-extension multiplier: shift-add on operand magnitudes,
// BPC multiplier bits per cycle, sign fix-up and result selection at the end.
module mul_unit #(
  parameter int XLEN  = 64,
  parameter int BPC   = 2,
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  mul_if.slave       i_bus,
  output logic       busy,
  output logic [1:0] o_dbg_state
);
  localparam int N_FULL = XLEN / BPC;
  localparam int N_WORD = 32 / BPC;
  localparam int CNT_W  = $clog2(N_FULL) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic               r_word;
  logic [TAG_W-1:0]   r_tag;
  logic               r_neg;
  logic [2*XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [2*XLEN-1:0]  r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]    r_result;
  logic               r_out_valid;

  logic               w_word;
  logic [1:0]         w_op;
  logic [XLEN-1:0]    w_a, w_b, w_mag_a, w_mag_b;
  logic               w_sa, w_sb, w_zero;
  logic               w_in_ready, w_accept;
  logic [2*XLEN-1:0]  w_pp, w_prod;
  logic [XLEN-1:0]    w_res;

  // Effective operands: word mode sign-extends the low halves and forces MUL.
  always_comb begin
    w_word  = (XLEN == 64) && i_bus.in_word;
    w_op    = w_word ? 2'b00 : i_bus.in_op;
    w_a     = w_word ? XLEN'($signed(i_bus.in_a[31:0])) : i_bus.in_a;
    w_b     = w_word ? XLEN'($signed(i_bus.in_b[31:0])) : i_bus.in_b;
    w_sa    = (w_op != 2'b11) && w_a[XLEN-1];
    w_sb    = (w_op[1] == 1'b0) && w_b[XLEN-1];
    w_mag_a = w_sa ? -w_a : w_a;
    w_mag_b = w_sb ? -w_b : w_b;
    w_zero  = (w_a == '0) || (w_b == '0);
  end

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    if (r_word)              w_res = XLEN'($signed(w_prod[31:0]));
    else if (r_op == 2'b00)  w_res = w_prod[XLEN-1:0];
    else                     w_res = w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = rst && !flush;
        if (i_bus.in_valid && w_in_ready) begin
          w_accept = 1'b1;
          w_next   = w_zero ? FIX : CALC;
        end
      end
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (r_out_valid && i_bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_word      <= 1'b0;
      r_tag       <= '0;
      r_neg       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= w_op;
        r_word   <= w_word;
        r_tag    <= i_bus.in_tag;
        r_neg    <= w_sa ^ w_sb;
        r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_acc    <= '0;
        r_cnt    <= w_word ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
      end
      if (r_state == CALC) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << BPC;
        r_mplier <= r_mplier >> BPC;
        r_cnt    <= r_cnt - 1'b1;
      end
      if (r_state == FIX) r_result <= w_res;
      // The result is presented one cycle after DONE is entered, giving N+2.
      r_out_valid <= (r_state == DONE) && !flush && !(r_out_valid && i_bus.out_ready);
    end
  end

  assign i_bus.in_ready   = w_in_ready;
  assign i_bus.out_valid  = r_out_valid;
  assign i_bus.out_result = r_result;
  assign i_bus.out_tag    = r_tag;
  assign busy             = (r_state != IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: doc/mul_unit.md
# mul_unit

Parametrised iterative integer multiplier for the execute stage, the successor to the current single-mode 64×64 multiplier. It adds RISC-V M-extension mode selection (MUL/MULH/MULHSU/MULHU, plus MULW when XLEN=64), a configurable number of product bits retired per cycle, valid/ready handshakes on both sides, a tag passthrough, a pipeline flush and a zero-operand early exit. It sits beside the main ALU and is issued by the EX stage; its result returns to the EX/MEM writeback mux.

## Interface
- XLEN, 64: operand and result width; must be 32 or 64.
- BPC, 2: multiplier bits retired per CALC cycle; must be 1, 2 or 4 and must divide XLEN.
- TAG_W, 5: width of the opaque tag (destination register index).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  kill any in-flight or completed-but-unconsumed operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts a request this cycle.
- in_op  in  2  00 MUL (low XLEN), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- in_word  in  1  32-bit word op (MULW); honoured only when XLEN=64, otherwise ignored.
- in_a, in_b  in  XLEN  operands (in_a is rs1; signed side for MULHSU).
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready = !flush. Accept on in_valid && in_ready. Capture the op, tag, signs, operand magnitudes (two's-complement negate when signed and MSB set) and the result sign = sign_a ^ sign_b.
- Signedness: MUL and MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned. MUL uses magnitudes as well; the low half equals the signed and unsigned product.
- Word mode (XLEN=64, in_word=1): operands are a[31:0] and b[31:0], signed. in_op is forced to MUL. The result is the 64-bit sign extension of product[31:0].
- Zero early exit: if either effective operand is zero, go IDLE→FIX directly with a zero product.
- Otherwise, IDLE→CALC. CALC is shift-add on magnitudes: each cycle, add (mcand × multiplier[BPC-1:0]) into a 2·XLEN accumulator, then shift the multiplier right by BPC. After N = XLEN/BPC cycles (N = 16 in word mode with XLEN=64), go to FIX.
- FIX: negate the 2·XLEN product if the result sign is set. Select the low XLEN bits for MUL, the high XLEN bits for the MULH variants, or the sign-extended low 32 bits for word mode. Register the result into out_result and go to DONE.
- DONE: out_valid=1, with out_result and out_tag stable. On out_ready go to IDLE. If out_ready is low, hold indefinitely.
- Magnitude of the most-negative value is 2^(XLEN-1) as an unsigned XLEN value; no overflow case exists.
- flush, in any state: next state is IDLE, out_valid=0 the next cycle, and the accumulator contents become don't-care. flush in the same cycle as in_valid means no accept (in_ready is low). flush has priority over out_ready.

## Timing
- While rst=0 at a clock edge: state goes to IDLE; out_valid=0, out_result=0, out_tag=0, busy=0. in_ready=0 while rst is low.
- Accept edge = T. Normal path: CALC for N cycles, FIX for 1 cycle, out_valid high from edge T+N+2.
  - XLEN=64, BPC=2: out_valid at T+34.
  - Word op with BPC=2: out_valid at T+18.
  - Zero operand: out_valid at T+2.
- Throughput: in_ready rises the cycle after the out handshake. There is no overlap; one operation is in flight at a time.
- in_a, in_b, in_op, in_word and in_tag are sampled only at the accept edge. Later changes on these inputs are ignored.
- out_result and out_tag do not change while out_valid=1.

## Test plan
- XLEN=64, BPC=2, MUL a=3, b=-5 → out_result=0xFFFFFFFFFFFFFFF1; out_valid exactly 34 cycles after accept; tag echoed.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0. MULHSU with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- MULH a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000. MUL with the same operands → 0.
- in_word=1, MUL a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE; out_valid at T+18.
- a=0, b=0x1234 (any op) → 0, out_valid at T+2. Then hold out_ready=0 for 10 cycles → result and tag stay stable; in_ready stays 0.
- Accept, assert flush 5 cycles later → IDLE next cycle, no out_valid. Then accept a new request the cycle after → its correct result only. Repeat with BPC=1 and BPC=4 builds, checking latencies of 66 and 18.
